forward_hazard_unit: RTL and testbench



---
 rtl/forward_hazard_unit_pkg.sv | 28 ++
 rtl/forward_hazard_unit_mux_slot.sv | 60 ++++++
 rtl/forward_hazard_unit.sv | 194 +++++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : forward_hazard_unit_pkg                                    |
// | Description : Shared types and defaults for the forwarding / hazard      |
// |               unit: FSM state enum, per-slot forward-select encodings    |
// |               and datapath/address width defaults.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package forward_hazard_unit_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int ABITS_DEFAULT = 5;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } fsm_state_t;

    // Forward-select codes, listed in priority order.
    typedef enum logic [1:0] {
        FWD_MEM = 2'd0,
        FWD_WB  = 2'd1,
        FWD_WB1 = 2'd2,
        FWD_RF  = 2'd3
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/forward_hazard_unit_mux_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fwd_mux_slot                                               |
// | Description : Priority operand select for one EX source slot.            |
// |               MEM ALU result > WB write data > WB1 (one cycle past WB)   |
// |               > register-file operand. Register 0 is never forwarded.    |
// | Ports       : rs            EX source address of this slot               |
// |               rf_data       operand read in ID                           |
// |               mem_*/wb_*    producer stages                              |
// |               wb1_*         delayed WB copy                              |
// |               data          resolved operand                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fwd_mux_slot
    import forward_hazard_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ABITS = ABITS_DEFAULT
)
(
    input  logic [ABITS-1:0] rs,
    input  logic [XLEN-1:0]  rf_data,
    input  logic [ABITS-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [XLEN-1:0]  mem_aluout,
    input  logic [ABITS-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic [XLEN-1:0]  wb_wd,
    input  logic             wb1_valid,
    input  logic [ABITS-1:0] wb1_rd,
    input  logic [XLEN-1:0]  wb1_data,
    output logic [XLEN-1:0]  data
);

    fwd_sel_t w_sel;

    // A load in MEM has no data yet (its ALU result is an address), so only
    // non-load MEM writers are eligible. wb1_valid already excludes x0.
    always_comb begin
        w_sel = FWD_RF;
        if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == rs))
            w_sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
            w_sel = FWD_WB;
        else if (wb1_valid && (wb1_rd == rs))
            w_sel = FWD_WB1;
    end

    always_comb begin
        case (w_sel)
            FWD_MEM: data = mem_aluout;
            FWD_WB:  data = wb_wd;
            FWD_WB1: data = wb1_data;
            default: data = rf_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : forward_hazard_unit                                        |
// | Description : Operand forwarding, load-use detection and data-memory     |
// |               wait handling for a 5-stage pipeline.                      |
// | Ports       : clk, rstn       clock, async active-low reset              |
// |               id_rs           ID source addresses (NSRC slots)           |
// |               ex_rs, ex_rdata EX source addresses / RF operands          |
// |               ex_*, mem_*, wb_* stage destination/enable/data            |
// |               mem_ready       load data returned this cycle              |
// |               fwd_data        resolved EX operands                       |
// |               stall_front     hold PC and IF/ID                          |
// |               bubble_ex       insert NOP into ID/EX                      |
// |               hold_all        freeze every pipeline register             |
// |               mem_timeout     sticky: a load waited MAX_WAIT cycles      |
// |               lu_cnt,wait_cnt saturating event counters                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NSRC     = 2,
    parameter int ABITS    = ABITS_DEFAULT,
    parameter int MAX_WAIT = 16
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NSRC*ABITS-1:0] id_rs,
    input  logic [NSRC*ABITS-1:0] ex_rs,
    input  logic [NSRC*XLEN-1:0]  ex_rdata,
    input  logic [ABITS-1:0]      ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [ABITS-1:0]      mem_rd,
    input  logic                  mem_regwrite,
    input  logic                  mem_memread,
    input  logic [XLEN-1:0]       mem_aluout,
    input  logic                  mem_ready,
    input  logic [ABITS-1:0]      wb_rd,
    input  logic                  wb_regwrite,
    input  logic [XLEN-1:0]       wb_wd,
    output logic [NSRC*XLEN-1:0]  fwd_data,
    output logic                  stall_front,
    output logic                  bubble_ex,
    output logic                  hold_all,
    output logic                  mem_timeout,
    output logic [31:0]           lu_cnt,
    output logic [31:0]           wait_cnt
);

    localparam int                c_WAIT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT    = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT_M1 = c_WAIT_W'(MAX_WAIT - 1);

    fsm_state_t            r_state;
    fsm_state_t            w_state_next;
    logic [c_WAIT_W-1:0]   r_wait_ctr;
    logic                  r_timeout;
    logic                  r_wb1_valid;
    logic [ABITS-1:0]      r_wb1_rd;
    logic [XLEN-1:0]       r_wb1_data;
    logic [31:0]           r_lu_cnt;
    logic [31:0]           r_wait_cnt;
    logic                  w_lu;
    logic                  w_hold_all;
    logic                  w_stall;

    // ------------------------------------------------------------------
    // Operand forwarding, one priority mux per EX source slot
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
            fwd_mux_slot #(
                .XLEN  (XLEN),
                .ABITS (ABITS)
            ) u_slot (
                .rs           (ex_rs[gi*ABITS +: ABITS]),
                .rf_data      (ex_rdata[gi*XLEN +: XLEN]),
                .mem_rd       (mem_rd),
                .mem_regwrite (mem_regwrite),
                .mem_memread  (mem_memread),
                .mem_aluout   (mem_aluout),
                .wb_rd        (wb_rd),
                .wb_regwrite  (wb_regwrite),
                .wb_wd        (wb_wd),
                .wb1_valid    (r_wb1_valid),
                .wb1_rd       (r_wb1_rd),
                .wb1_data     (r_wb1_data),
                .data         (fwd_data[gi*XLEN +: XLEN])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load-use detection: EX load whose destination feeds the ID instr
    // ------------------------------------------------------------------
    always_comb begin
        w_lu = 1'b0;
        if (ex_memread && ex_regwrite && (ex_rd != '0)) begin
            for (int i = 0; i < NSRC; i++) begin
                if (id_rs[i*ABITS +: ABITS] == ex_rd)
                    w_lu = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control decode. Hold wins over load-use: while frozen, the load-use
    // pair stays in place and is re-evaluated when the hold drops.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hold_all   = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_memread && !mem_ready) begin
                    w_hold_all   = 1'b1;
                    w_state_next = ST_MEM_WAIT;
                end else begin
                    w_stall = w_lu;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    w_hold_all = 1'b1;
                end else begin
                    w_stall      = w_lu;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign hold_all    = w_hold_all;
    assign stall_front = w_stall;
    assign bubble_ex   = w_stall;
    assign mem_timeout = r_timeout;
    assign lu_cnt      = r_lu_cnt;
    assign wait_cnt    = r_wait_cnt;

    // ------------------------------------------------------------------
    // FSM with wait-episode counter and sticky timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_RUN;
            r_wait_ctr <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_RUN) begin
                if (w_state_next == ST_MEM_WAIT)
                    r_wait_ctr <= '0;
            end else begin
                // Saturate at MAX_WAIT; the wait itself continues past it.
                if (r_wait_ctr != c_MAX_WAIT)
                    r_wait_ctr <= r_wait_ctr + 1'b1;
                if (r_wait_ctr >= c_MAX_WAIT_M1)
                    r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // WB1 copy (covers read-before-write RF) and event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb1_valid <= 1'b0;
            r_wb1_rd    <= '0;
            r_wb1_data  <= '0;
            r_lu_cnt    <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (!w_hold_all) begin
                r_wb1_valid <= wb_regwrite && (wb_rd != '0);
                r_wb1_rd    <= wb_rd;
                r_wb1_data  <= wb_wd;
            end
            if (w_stall && (r_lu_cnt != 32'hFFFF_FFFF))
                r_lu_cnt <= r_lu_cnt + 32'd1;
            if (w_hold_all && (r_wait_cnt != 32'hFFFF_FFFF))
                r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_forward_hazard_unit                                     |
// | Description : Self-checking bench: directed scenarios with literal       |
// |               expectations, then randomized traffic against a            |
// |               behavioural model of forwarding and hazard rules.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_forward_hazard_unit;

    localparam int XLEN     = 32;
    localparam int NSRC     = 2;
    localparam int ABITS    = 5;
    localparam int MAX_WAIT = 4;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NSRC*ABITS-1:0] id_rs, ex_rs;
    logic [NSRC*XLEN-1:0]  ex_rdata;
    logic [ABITS-1:0]      ex_rd, mem_rd, wb_rd;
    logic                  ex_regwrite, ex_memread;
    logic                  mem_regwrite, mem_memread, mem_ready;
    logic [XLEN-1:0]       mem_aluout, wb_wd;
    logic                  wb_regwrite;
    logic [NSRC*XLEN-1:0]  fwd_data;
    logic                  stall_front, bubble_ex, hold_all, mem_timeout;
    logic [31:0]           lu_cnt, wait_cnt;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit              m_waiting;
    int              m_episode;
    bit              m_timeout;
    longint unsigned m_lu, m_wait;
    bit              m_wb1_valid;
    logic [ABITS-1:0] m_wb1_rd;
    logic [XLEN-1:0]  m_wb1_data;
    bit              e_hold, e_stall;

    forward_hazard_unit #(
        .XLEN(XLEN), .NSRC(NSRC), .ABITS(ABITS), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rstn(rstn), .id_rs(id_rs), .ex_rs(ex_rs), .ex_rdata(ex_rdata),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_aluout(mem_aluout), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_wd(wb_wd),
        .fwd_data(fwd_data), .stall_front(stall_front), .bubble_ex(bubble_ex),
        .hold_all(hold_all), .mem_timeout(mem_timeout),
        .lu_cnt(lu_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; ex_rs = '0; ex_rdata = '0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
        mem_aluout = '0; mem_ready = 1'b1;
        wb_rd = '0; wb_regwrite = 1'b0; wb_wd = '0;
    endtask

    task automatic model_reset();
        m_waiting = 0; m_episode = 0; m_timeout = 0;
        m_lu = 0; m_wait = 0;
        m_wb1_valid = 0; m_wb1_rd = '0; m_wb1_data = '0;
    endtask

    function automatic logic [XLEN-1:0] exp_fwd(input int i);
        logic [ABITS-1:0] s;
        s = ex_rs[i*ABITS +: ABITS];
        if (mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == s) return mem_aluout;
        if (wb_regwrite && wb_rd != 0 && wb_rd == s) return wb_wd;
        if (m_wb1_valid && m_wb1_rd == s) return m_wb1_data;
        return ex_rdata[i*XLEN +: XLEN];
    endfunction

    // Move to the falling edge, derive expectations from the rules, compare.
    task automatic settle();
        bit lu, outstanding;
        @(negedge clk);
        lu = 0;
        if (ex_memread && ex_regwrite && ex_rd != 0)
            for (int i = 0; i < NSRC; i++)
                if (id_rs[i*ABITS +: ABITS] == ex_rd) lu = 1;
        // A load is outstanding if we are already waiting or one just arrived in MEM.
        outstanding = m_waiting || mem_memread;
        e_hold  = outstanding && !mem_ready;
        e_stall = !e_hold && lu;
        chk("hold_all",    64'(hold_all),    64'(e_hold));
        chk("stall_front", 64'(stall_front), 64'(e_stall));
        chk("bubble_ex",   64'(bubble_ex),   64'(e_stall));
        chk("mem_timeout", 64'(mem_timeout), 64'(m_timeout));
        chk("lu_cnt",      64'(lu_cnt),      m_lu);
        chk("wait_cnt",    64'(wait_cnt),    m_wait);
        for (int i = 0; i < NSRC; i++)
            chk($sformatf("fwd_data[%0d]", i), 64'(fwd_data[i*XLEN +: XLEN]), 64'(exp_fwd(i)));
    endtask

    // Rising edge: advance the model using the values that were settled.
    task automatic advance();
        @(posedge clk);
        if (e_stall && m_lu   < 64'hFFFF_FFFF) m_lu++;
        if (e_hold  && m_wait < 64'hFFFF_FFFF) m_wait++;
        if (!e_hold) begin
            m_wb1_valid = wb_regwrite && wb_rd != 0;
            m_wb1_rd    = wb_rd;
            m_wb1_data  = wb_wd;
        end
        if (m_waiting) begin
            m_episode++;
            if (m_episode >= MAX_WAIT) m_timeout = 1;
            if (mem_ready) m_waiting = 0;
        end else if (mem_memread && !mem_ready) begin
            m_waiting = 1;
            m_episode = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst hold_all",    64'(hold_all),    64'd0);
        chk("rst stall_front", 64'(stall_front), 64'd0);
        chk("rst bubble_ex",   64'(bubble_ex),   64'd0);
        chk("rst mem_timeout", 64'(mem_timeout), 64'd0);
        chk("rst lu_cnt",      64'(lu_cnt),      64'd0);
        chk("rst wait_cnt",    64'(wait_cnt),    64'd0);
        chk("rst fwd_data",    64'(fwd_data),    64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // MEM beats WB for the same register
        mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
        ex_rs[0 +: ABITS] = 5; mem_aluout = 32'hAAAA; wb_wd = 32'hBBBB;
        settle();
        chk("prec fwd0", 64'(fwd_data[0 +: XLEN]), 64'h0000_AAAA);
        advance();

        // x0 is never forwarded
        clear_inputs();
        mem_regwrite = 1; wb_regwrite = 1; ex_regwrite = 1;
        ex_rdata[0 +: XLEN] = 32'h1234; mem_aluout = 32'h5555; wb_wd = 32'h6666;
        settle();
        chk("x0 fwd0", 64'(fwd_data[0 +: XLEN]), 64'h1234);
        advance();

        // WB1 covers the cycle after WB
        clear_inputs();
        wb_rd = 7; wb_wd = 32'h77; wb_regwrite = 1;
        settle(); advance();
        clear_inputs();
        ex_rs[ABITS +: ABITS] = 7; ex_rdata[XLEN +: XLEN] = 32'hDEAD;
        settle();
        chk("wb1 fwd1", 64'(fwd_data[XLEN +: XLEN]), 64'h77);
        advance();

        // load-use: one stall cycle
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs[0 +: ABITS] = 3;
        settle();
        chk("lu stall", 64'(stall_front), 64'd1);
        chk("lu bubble", 64'(bubble_ex), 64'd1);
        advance();
        clear_inputs();
        settle();
        chk("lu cnt", 64'(lu_cnt), 64'd1);
        advance();

        // three-cycle memory wait
        clear_inputs();
        mem_memread = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("wait hold", 64'(hold_all), 64'd1);
            advance();
        end
        mem_ready = 1;
        settle();
        chk("wait release", 64'(hold_all), 64'd0);
        advance();
        clear_inputs();
        mem_ready = 0;
        settle();
        chk("wait cnt", 64'(wait_cnt), 64'd3);
        chk("back in run", 64'(hold_all), 64'd0);
        advance();

        // timeout after MAX_WAIT wait cycles, then reset clears everything
        clear_inputs();
        mem_memread = 1; mem_ready = 0;
        for (int k = 0; k < 4; k++) begin settle(); advance(); end
        settle();
        chk("pre timeout", 64'(mem_timeout), 64'd0);
        advance();
        settle();
        chk("timeout", 64'(mem_timeout), 64'd1);
        chk("timeout hold", 64'(hold_all), 64'd1);
        advance();
        do_reset();
        clear_inputs();
        mem_ready = 0;
        settle();
        chk("post rst run", 64'(hold_all), 64'd0);
        advance();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int i = 0; i < NSRC; i++) begin
                id_rs[i*ABITS +: ABITS]    = ABITS'($urandom_range(0, 7));
                ex_rs[i*ABITS +: ABITS]    = ABITS'($urandom_range(0, 7));
                ex_rdata[i*XLEN +: XLEN]   = $urandom;
            end
            ex_rd        = ABITS'($urandom_range(0, 7));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_memread   = ($urandom_range(0, 2) == 0);
            mem_rd       = ABITS'($urandom_range(0, 7));
            mem_regwrite = ($urandom_range(0, 3) != 0);
            mem_memread  = ($urandom_range(0, 3) == 0);
            mem_aluout   = $urandom;
            mem_ready    = ($urandom_range(0, 2) != 0);
            wb_rd        = ABITS'($urandom_range(0, 7));
            wb_regwrite  = ($urandom_range(0, 3) != 0);
            wb_wd        = $urandom;
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
